// File: rtl/lockstep_pkg.sv
// Shared definitions for the lockstep synchroniser: FSM states, default
// channel count, data width, timeout and phase-counter width.
package lockstep_pkg;

  localparam int unsigned DEF_NB_CORES   = 8;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT    = 255;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    GATHER_GNT,
    RELEASE_GNT,
    GATHER_RSP,
    RELEASE_RSP
  } state_e;

endpackage

// File: rtl/lockstep_chan.sv
// One core/memory channel: masks the forwarded request, remembers whether the
// grant and response have been seen, and captures the response data.
module lockstep_chan
  import lockstep_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  drive_i,
  input  logic                  gnt_phase_i,
  input  logic                  rsp_phase_i,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  req_o,
  output logic                  gnt_done_o,
  output logic                  rsp_done_o,
  output logic [DATA_WIDTH-1:0] capture_o
);

  logic                  gnt_seen_q, gnt_seen_d;
  logic                  rsp_seen_q, rsp_seen_d;
  logic [DATA_WIDTH-1:0] capture_q, capture_d;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    gnt_seen_d = gnt_seen_q;
    rsp_seen_d = rsp_seen_q;
    capture_d  = capture_q;
    if (clear_i) begin
      gnt_seen_d = 1'b0;
      rsp_seen_d = 1'b0;
    end else begin
      if (gnt_phase_i && drive_i && gnt_i) gnt_seen_d = 1'b1;
      if (rsp_phase_i && drive_i && rvalid_i) begin
        rsp_seen_d = 1'b1;
        capture_d  = rdata_i;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only; blocking ones would race other flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_seen_q <= 1'b0;
      rsp_seen_q <= 1'b0;
      // NOTE: the capture register is reset because released data must read 0 after reset.
      capture_q  <= '0;
    end else begin
      gnt_seen_q <= gnt_seen_d;
      rsp_seen_q <= rsp_seen_d;
      capture_q  <= capture_d;
    end
  end

  // Undriven channels count as done; "done" includes an event arriving this cycle.
  assign req_o      = gnt_phase_i & drive_i & ~gnt_seen_q;
  assign gnt_done_o = ~drive_i | gnt_seen_q | gnt_i;
  assign rsp_done_o = ~drive_i | rsp_seen_q | rvalid_i;
  assign capture_o  = capture_q;

endmodule

// File: rtl/lockstep_sync.sv
// Lockstep synchroniser: gathers per-core grants/responses and releases them to
// all participating cores in the same cycle, or passes everything through.
module lockstep_sync
  import lockstep_pkg::*;
#(
  parameter int unsigned NB_CORES   = DEF_NB_CORES,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                lockstep_en_i,
  input  logic                                bcast_i,
  input  logic [NB_CORES-1:0]                 req_i,
  output logic [NB_CORES-1:0]                 gnt_o,
  output logic [NB_CORES-1:0]                 rvalid_o,
  output logic [NB_CORES-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic [NB_CORES-1:0]                 req_o,
  input  logic [NB_CORES-1:0]                 gnt_i,
  input  logic [NB_CORES-1:0]                 rvalid_i,
  input  logic [NB_CORES-1:0][DATA_WIDTH-1:0] rdata_i,
  output logic                                err_timeout_o,
  input  logic                                err_clr_i
);

  // Reset asserts asynchronously and is released synchronously to clk_i.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                             state_q, state_d;
  logic [NB_CORES-1:0]                part_mask_q, part_mask_d;
  logic                               bcast_q, bcast_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d, cnt_inc;
  logic                               err_q, err_d;
  logic [NB_CORES-1:0][DATA_WIDTH-1:0] hold_q, hold_d;

  logic [NB_CORES-1:0]                 leader, drive, chan_req, gnt_done, rsp_done;
  logic [NB_CORES-1:0][DATA_WIDTH-1:0] capture, rel_data;
  logic [DATA_WIDTH-1:0]               leader_data;
  logic start, gnt_phase, rsp_phase, in_gather, timeout_hit, transparent;

  // A broadcast is issued once, on the lowest participating channel.
  assign leader      = part_mask_q & (~part_mask_q + NB_CORES'(1));
  assign drive       = bcast_q ? leader : part_mask_q;
  assign start       = (state_q == IDLE) && lockstep_en_i && (|req_i);
  assign gnt_phase   = (state_q == GATHER_GNT);
  assign rsp_phase   = (state_q == GATHER_GNT) || (state_q == RELEASE_GNT) ||
                       (state_q == GATHER_RSP);
  assign in_gather   = (state_q == GATHER_GNT) || (state_q == GATHER_RSP);
  assign transparent = (state_q == IDLE) && !lockstep_en_i;

  for (genvar g = 0; g < NB_CORES; g++) begin : g_chan
    lockstep_chan #(.DATA_WIDTH(DATA_WIDTH)) u_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_n),
      .clear_i     (start),
      .drive_i     (drive[g]),
      .gnt_phase_i (gnt_phase),
      .rsp_phase_i (rsp_phase),
      .gnt_i       (gnt_i[g]),
      .rvalid_i    (rvalid_i[g]),
      .rdata_i     (rdata_i[g]),
      .req_o       (chan_req[g]),
      .gnt_done_o  (gnt_done[g]),
      .rsp_done_o  (rsp_done[g]),
      .capture_o   (capture[g])
    );
  end

  always_comb begin
    leader_data = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      if (leader[k]) leader_data = capture[k];
    end
    for (int k = 0; k < NB_CORES; k++) begin
      rel_data[k] = bcast_q ? leader_data : capture[k];
    end
  end

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = in_gather && (cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    part_mask_d = part_mask_q;
    bcast_d     = bcast_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          part_mask_d = req_i;
          bcast_d     = bcast_i;
          cnt_d       = '0;
          state_d     = GATHER_GNT;
        end
      end
      GATHER_GNT: begin
        cnt_d = cnt_inc;
        if (&gnt_done) state_d = RELEASE_GNT;
      end
      RELEASE_GNT: begin
        cnt_d   = '0;
        state_d = GATHER_RSP;
      end
      GATHER_RSP: begin
        cnt_d = cnt_inc;
        if (&rsp_done) state_d = RELEASE_RSP;
      end
      RELEASE_RSP: begin
        hold_d  = rel_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A timeout set in the same cycle as a clear wins.
  always_comb begin
    err_d = err_q;
    if (timeout_hit)    err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      part_mask_q <= '0;
      bcast_q     <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      part_mask_q <= part_mask_d;
      bcast_q     <= bcast_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    if (transparent) begin
      req_o    = req_i;
      gnt_o    = gnt_i;
      rvalid_o = rvalid_i;
      rdata_o  = rdata_i;
    end else begin
      req_o    = chan_req;
      gnt_o    = (state_q == RELEASE_GNT) ? part_mask_q : '0;
      rvalid_o = (state_q == RELEASE_RSP) ? part_mask_q : '0;
      rdata_o  = (state_q == RELEASE_RSP) ? rel_data : hold_q;
    end
  end

  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_lockstep_sync.sv
// Directed self-checking bench for lockstep_sync (8 channels, timeout 10).
module tb_lockstep_sync;

  localparam int unsigned NB = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 10;

  logic                   clk_i, rst_ni, lockstep_en_i, bcast_i, err_clr_i, err_timeout_o;
  logic [NB-1:0]          req_i, gnt_o, rvalid_o, req_o, gnt_i, rvalid_i;
  logic [NB-1:0][DW-1:0]  rdata_o, rdata_i;

  int n_total = 0;
  int n_bad   = 0;

  lockstep_sync #(.NB_CORES(NB), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .lockstep_en_i (lockstep_en_i),
    .bcast_i       (bcast_i),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .req_o         (req_o),
    .gnt_i         (gnt_i),
    .rvalid_i      (rvalid_i),
    .rdata_i       (rdata_i),
    .err_timeout_o (err_timeout_o),
    .err_clr_i     (err_clr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  logic [NB-1:0] gnt_seq [6] = '{8'h03, 8'h00, 8'h3C, 8'h00, 8'h00, 8'hC0};
  logic [NB-1:0] req_seq [6] = '{8'hFF, 8'hFC, 8'hFC, 8'hC0, 8'hC0, 8'hC0};

  initial begin
    rst_ni = 1'b0; lockstep_en_i = 1'b1; bcast_i = 1'b0; err_clr_i = 1'b0;
    req_i = '1; gnt_i = '0; rvalid_i = '0; rdata_i = '0;

    // Reset state
    #12;
    check("rst req_o", req_o, 0);
    check("rst gnt_o", gnt_o, 0);
    check("rst rvalid_o", rvalid_o, 0);
    check("rst err", err_timeout_o, 0);
    check("rst rdata_o0", rdata_o[0], 0);
    req_i = '0;
    rst_ni = 1'b1;
    tick(); tick(); tick();

    // Grants spread over cycles 1, 3, 6 of the gather phase
    req_i = 8'hFF;
    mid(); check("t1 idle req_o", req_o, 0);
    tick();
    for (int c = 0; c < 6; c++) begin
      gnt_i = gnt_seq[c];
      mid();
      check($sformatf("t1 req_o c%0d", c + 1), req_o, req_seq[c]);
      check($sformatf("t1 gnt_o c%0d", c + 1), gnt_o, 0);
      tick();
    end
    gnt_i = '0;
    mid(); check("t1 gnt release", gnt_o, 8'hFF); check("t1 req_o release", req_o, 0);
    tick();
    req_i = '0; rvalid_i = 8'hFF;
    for (int k = 0; k < NB; k++) rdata_i[k] = 32'h100 + k;
    mid(); check("t1 rvalid early", rvalid_o, 0);
    tick();
    rvalid_i = '0; rdata_i = '0;
    mid();
    check("t1 rvalid", rvalid_o, 8'hFF);
    check("t1 rdata3", rdata_o[3], 32'h103);
    check("t1 rdata7", rdata_o[7], 32'h107);
    tick();
    mid(); check("t1 rvalid after", rvalid_o, 0); check("t1 rdata3 hold", rdata_o[3], 32'h103);

    // Broadcast
    req_i = 8'hFF; bcast_i = 1'b1;
    tick();
    bcast_i = 1'b0; gnt_i = 8'h01;
    mid(); check("t2 bcast req_o", req_o, 8'h01);
    tick();
    gnt_i = '0;
    mid(); check("t2 gnt_o", gnt_o, 8'hFF);
    tick();
    req_i = '0; rvalid_i = 8'h05;
    rdata_i[0] = 32'hCAFE0001; rdata_i[2] = 32'h0BAD0002; rdata_i[7] = 32'h0BAD0007;
    mid(); check("t2 rvalid early", rvalid_o, 0);
    tick();
    rvalid_i = '0; rdata_i = '0;
    mid();
    check("t2 rvalid", rvalid_o, 8'hFF);
    check("t2 rdata0", rdata_o[0], 32'hCAFE0001);
    check("t2 rdata2", rdata_o[2], 32'hCAFE0001);
    check("t2 rdata7", rdata_o[7], 32'hCAFE0001);
    tick();

    // Responses four cycles apart
    req_i = 8'h05;
    tick();
    gnt_i = 8'h05;
    mid(); check("t3 req_o", req_o, 8'h05);
    tick();
    gnt_i = '0;
    mid(); check("t3 gnt_o", gnt_o, 8'h05);
    tick();
    req_i = '0; rvalid_i = 8'h01; rdata_i[0] = 32'h11;
    tick();
    rvalid_i = '0; rdata_i = '0;
    for (int i = 0; i < 3; i++) begin
      mid(); check($sformatf("t3 wait%0d", i), rvalid_o, 0);
      tick();
    end
    rvalid_i = 8'h04; rdata_i[2] = 32'h22; rdata_i[0] = 32'h99;
    mid(); check("t3 rvalid t+4", rvalid_o, 0);
    tick();
    rvalid_i = '0; rdata_i = '0;
    mid();
    check("t3 rvalid t+5", rvalid_o, 8'h05);
    check("t3 rdata0", rdata_o[0], 32'h11);
    check("t3 rdata2", rdata_o[2], 32'h22);
    tick();

    // Timeout with clear held: set wins on the timeout cycle
    req_i = 8'h01; err_clr_i = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      mid();
      check($sformatf("t4 err c%0d", c), err_timeout_o, 0);
      tick();
    end
    err_clr_i = 1'b0;
    mid(); check("t4 err set", err_timeout_o, 1); check("t4 still waiting", req_o, 8'h01);
    tick();
    gnt_i = 8'h01;
    mid(); check("t4 gnt not yet", gnt_o, 0);
    tick();
    gnt_i = '0;
    mid(); check("t4 late gnt", gnt_o, 8'h01); check("t4 err sticky", err_timeout_o, 1);
    tick();
    req_i = '0; rvalid_i = 8'h01; rdata_i[0] = 32'h33; err_clr_i = 1'b1;
    tick();
    rvalid_i = '0; rdata_i = '0; err_clr_i = 1'b0;
    mid();
    check("t4 err cleared", err_timeout_o, 0);
    check("t4 rvalid", rvalid_o, 8'h01);
    check("t4 rdata0", rdata_o[0], 32'h33);
    tick();

    // Transparent mode and mid-transaction mode toggle
    lockstep_en_i = 1'b0;
    req_i = 8'h5A; gnt_i = 8'h33; rvalid_i = 8'h0F; rdata_i[1] = 32'h1234;
    #1;
    check("t5 pt req", req_o, 8'h5A);
    check("t5 pt gnt", gnt_o, 8'h33);
    check("t5 pt rvalid", rvalid_o, 8'h0F);
    check("t5 pt rdata1", rdata_o[1], 32'h1234);
    tick();
    mid(); check("t5 pt stays idle", req_o, 8'h5A);
    lockstep_en_i = 1'b1; req_i = 8'h03; gnt_i = '0; rvalid_i = '0; rdata_i = '0;
    tick();
    lockstep_en_i = 1'b0; gnt_i = 8'h03;
    mid(); check("t5 toggle req_o", req_o, 8'h03); check("t5 toggle gnt_o", gnt_o, 0);
    tick();
    gnt_i = '0;
    mid(); check("t5 toggle release", gnt_o, 8'h03);
    tick();
    req_i = '0; rvalid_i = 8'h03; rdata_i[0] = 32'hAA; rdata_i[1] = 32'hBB;
    mid(); check("t5 toggle rvalid early", rvalid_o, 0);
    tick();
    rvalid_i = '0; rdata_i = '0;
    mid(); check("t5 toggle rvalid", rvalid_o, 8'h03); check("t5 toggle rdata1", rdata_o[1], 32'hBB);
    tick();
    req_i = 8'h81;
    #1; check("t5 pt after idle", req_o, 8'h81);
    req_i = '0; lockstep_en_i = 1'b1;

    // Reset during response gathering
    req_i = 8'h0F;
    tick();
    gnt_i = 8'h0F;
    tick();
    gnt_i = '0;
    tick();
    req_i = '0; rvalid_i = 8'h03; rdata_i[0] = 32'h55;
    tick();
    rvalid_i = '0; rdata_i = '0;
    mid(); check("t6 waiting", rvalid_o, 0);
    #1 rst_ni = 1'b0;
    #1;
    check("t6 rst rdata1", rdata_o[1], 0);
    check("t6 rst rdata0", rdata_o[0], 0);
    check("t6 rst req_o", req_o, 0);
    check("t6 rst gnt_o", gnt_o, 0);
    rvalid_i = 8'h0C;
    tick();
    rst_ni = 1'b1; rvalid_i = '0;
    for (int i = 0; i < 6; i++) begin
      mid();
      check($sformatf("t6 no rvalid %0d", i), rvalid_o, 0);
      check($sformatf("t6 no gnt %0d", i), gnt_o, 0);
      tick();
    end
    req_i = 8'h02;
    tick();
    gnt_i = 8'h02;
    tick();
    gnt_i = '0; req_i = '0;
    mid(); check("t6 post-reset gnt", gnt_o, 8'h02);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lockstep_sync.md
LOCKSTEP_SYNC -- requirements
Module: lockstep_sync

Interface
REQ-001 Parameter NB_CORES, default 8, number of core/memory channel pairs (2..16).
REQ-002 Parameter DATA_WIDTH, default 32, rdata width per channel.
REQ-003 Parameter TIMEOUT, default 255, max cycles per phase before error (1..65535).
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 lockstep_en_i  in  1  1 = lockstep synchronisation, 0 = transparent pass-through.
REQ-007 bcast_i  in  1  same-address broadcast; qualifies the transaction being captured.
REQ-008 req_i  in  NB_CORES  core requests, held until gnt_o.
REQ-009 gnt_o  out  NB_CORES  grants to cores.
REQ-010 rvalid_o  out  NB_CORES  response valids to cores.
REQ-011 rdata_o  out  NB_CORES x DATA_WIDTH  response data to cores.
REQ-012 req_o  out  NB_CORES  requests to memory interconnect.
REQ-013 gnt_i  in  NB_CORES  grants from memory.
REQ-014 rvalid_i  in  NB_CORES  response valids from memory.
REQ-015 rdata_i  in  NB_CORES x DATA_WIDTH  response data from memory.
REQ-016 err_timeout_o  out  1  sticky timeout flag.
REQ-017 err_clr_i  in  1  clears err_timeout_o.

Function
REQ-018 FSM states IDLE, GATHER_GNT, RELEASE_GNT, GATHER_RSP, RELEASE_RSP; mode changes take effect only in IDLE.
REQ-019 Transparent mode (lockstep_en_i=0 in IDLE): req_o=req_i, gnt_o=gnt_i, rvalid_o=rvalid_i, rdata_o=rdata_i combinationally; FSM stays IDLE.
REQ-020 IDLE, lockstep, any req_i high: capture part_mask=req_i and bcast_q=bcast_i; clear gnt/rvalid collection masks; go GATHER_GNT next cycle.
REQ-021 GATHER_GNT: req_o[k]=part_mask[k] & ~gnt_seen[k] (non-broadcast); broadcast drives only req_o[lowest set bit of part_mask]; non-participating req_o=0.
REQ-022 gnt_i[k] on a driven channel sets gnt_seen[k]; gnt_i on undriven channels ignored.
REQ-023 When gnt_seen covers all driven channels (including grants arriving that cycle) go RELEASE_GNT.
REQ-024 RELEASE_GNT (one cycle): gnt_o=part_mask, all simultaneously; gnt_o=0 in every other state in lockstep; go GATHER_RSP.
REQ-025 GATHER_RSP: rvalid_i[k] on a driven channel stores rdata_i[k] into capture register k and sets rsp_seen[k]; rvalid_i arriving during GATHER_GNT also captured.
REQ-026 All driven channels seen: go RELEASE_RSP; rvalid_o=part_mask for exactly one cycle; rdata_o[k]=capture[k], or in broadcast capture[leader] for every k; go IDLE.
REQ-027 Latency: gnt_o one cycle after last gnt_i; rvalid_o one cycle after last rvalid_i; a new transaction may be captured in the cycle after RELEASE_RSP.
REQ-028 req_i rising on a non-participating channel mid-transaction is not forwarded; it is served by the next transaction.
REQ-029 part_mask with a single bit behaves as a one-channel transaction (no broadcast replication needed).
REQ-030 Phase counter (16 bit) counts cycles in GATHER_GNT/GATHER_RSP, resets on phase entry; on reaching TIMEOUT set err_timeout_o; FSM keeps waiting (no forced release).
REQ-031 err_clr_i clears err_timeout_o; simultaneous set and clear: set wins.
REQ-032 rdata_o outside RELEASE_RSP in lockstep holds last released values.

Reset
REQ-033 rst_ni low: FSM IDLE, masks, counter, capture registers, rdata_o 0; gnt_o, rvalid_o, req_o, err_timeout_o 0 (lockstep view); asynchronous assert, synchronous deassert.
REQ-034 Reset mid-transaction abandons it; no gnt_o/rvalid_o pulse afterwards for it.

Structure
REQ-035 Package lockstep_pkg holds state enum, default NB_CORES/DATA_WIDTH/TIMEOUT and counter width.
REQ-036 One sub-module lockstep_chan per channel: req masking, gnt_seen/rsp_seen flags, rdata capture register.

Verification
REQ-037 NB_CORES=8, req_i=0xFF, gnt_i bits over cycles 1,3,6 -> gnt_o=0xFF one cycle after the last gnt, never earlier.
REQ-038 bcast_i=1, req_i=0xFF -> req_o=0x01 only; gnt_i[0] -> gnt_o=0xFF; rdata_i[0]=0xCAFE0001 -> all rdata_o=0xCAFE0001 with rvalid_o=0xFF.
REQ-039 req_i=0x05, rvalid_i[0] data 0x11 at t, rvalid_i[2] data 0x22 at t+4 -> rvalid_o=0x05 at t+5, rdata_o[0]=0x11, rdata_o[2]=0x22.
REQ-040 TIMEOUT=10, gnt_i withheld -> err_timeout_o=1 at cycle 10 of GATHER_GNT; late gnt completes normally; err_clr_i clears flag.
REQ-041 lockstep_en_i=0 -> all channels pass-through in zero cycles; toggle mid-transaction -> change applied only after return to IDLE.
REQ-042 rst_ni asserted in GATHER_RSP -> outputs 0 immediately; no rvalid_o after release.
